// File: rtl/alu_disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_disp_pkg                                                               |
// | Op codes and active-low {g,f,e,d,c,b,a} glyphs for the ALU result display. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_disp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_D_LC  = 7'h21;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_B_LC  = 7'h03;
  localparam logic [6:0] SEG_O_LC  = 7'h23;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = SEG_0;
      4'd1:    digit_glyph = SEG_1;
      4'd2:    digit_glyph = SEG_2;
      4'd3:    digit_glyph = SEG_3;
      4'd4:    digit_glyph = SEG_4;
      4'd5:    digit_glyph = SEG_5;
      4'd6:    digit_glyph = SEG_6;
      4'd7:    digit_glyph = SEG_7;
      4'd8:    digit_glyph = SEG_8;
      4'd9:    digit_glyph = SEG_9;
      default: digit_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_display_glyph.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_glyph                                                                 |
// | Combinational glyph lookup for one display digit slot.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_glyph
  import alu_disp_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic [1:0] i_op,
  input  logic [3:0] i_result,
  input  logic       i_flag,
  output logic [6:0] o_seg_n
);

  logic       w_ge10;
  logic [3:0] w_units;

  always_comb begin
    w_ge10  = (i_result >= 4'd10);
    w_units = w_ge10 ? (i_result - 4'd10) : i_result;
    o_seg_n = SEG_BLANK;
    case (i_sel)
      2'd3: begin
        case (i_op)
          OP_ADD:  o_seg_n = SEG_A;
          OP_SUB:  o_seg_n = SEG_S;
          OP_MUL:  o_seg_n = SEG_P;
          default: o_seg_n = SEG_D_LC;
        endcase
      end
      2'd2: begin
        // The flag glyph names what the flag means for the current op.
        if (i_flag) begin
          case (i_op)
            OP_ADD:  o_seg_n = SEG_C;
            OP_SUB:  o_seg_n = SEG_B_LC;
            OP_MUL:  o_seg_n = SEG_O_LC;
            default: o_seg_n = SEG_E;
          endcase
        end
      end
      2'd1: begin
        if (w_ge10) o_seg_n = SEG_1;
      end
      default: o_seg_n = digit_glyph(w_units);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_result_display                                                         |
// | Captures ALU results and shows them on a 4-digit multiplexed 7-seg display.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int SCAN_DIV    = 25000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [1:0] op,
  input  logic [3:0] result,
  input  logic       flag,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       dp_n,
  output logic       disp_vld
);

  localparam int C_PRE_W = $clog2(SCAN_DIV);
  localparam int C_BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(SCAN_DIV - 1);
  localparam logic [C_BLK_W-1:0] C_BLK_MAX = C_BLK_W'(BLINK_TICKS - 1);

  logic [C_PRE_W-1:0] r_pre;
  logic [1:0]         r_idx;
  logic               r_pend;
  logic [1:0]         r_p_op, r_d_op;
  logic [3:0]         r_p_result, r_d_result;
  logic               r_p_flag, r_d_flag;
  logic               r_vld;
  logic [C_BLK_W-1:0] r_blk_cnt;
  logic               r_phase;
  logic [6:0]         r_seg_n;
  logic [3:0]         r_an_n;

  logic       w_tick, w_commit, w_err;
  logic [6:0] w_glyph;

  assign w_tick   = (r_pre == C_PRE_MAX);
  // Commits happen only at the 3->0 wrap so a frame never mixes old and new values.
  assign w_commit = w_tick && (r_idx == 2'd3) && (r_pend || upd);
  assign w_err    = (r_d_op == OP_DIV) && r_d_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= 2'd0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + C_PRE_W'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= 1'b0;
      r_p_op     <= 2'd0;
      r_p_result <= 4'd0;
      r_p_flag   <= 1'b0;
      r_d_op     <= 2'd0;
      r_d_result <= 4'd0;
      r_d_flag   <= 1'b0;
      r_vld      <= 1'b0;
    end else if (w_commit) begin
      r_pend <= 1'b0;
      r_vld  <= 1'b1;
      if (upd) begin
        r_d_op     <= op;
        r_d_result <= result;
        r_d_flag   <= flag;
      end else begin
        r_d_op     <= r_p_op;
        r_d_result <= r_p_result;
        r_d_flag   <= r_p_flag;
      end
    end else if (upd) begin
      r_pend     <= 1'b1;
      r_p_op     <= op;
      r_p_result <= result;
      r_p_flag   <= flag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b1;
    end else if (!w_err) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b1;
    end else if (w_tick) begin
      if (r_blk_cnt == C_BLK_MAX) begin
        r_blk_cnt <= '0;
        r_phase   <= ~r_phase;
      end else begin
        r_blk_cnt <= r_blk_cnt + C_BLK_W'(1);
      end
    end
  end

  seg7_glyph u_glyph (
    .i_sel    (r_idx),
    .i_op     (r_d_op),
    .i_result (r_d_result),
    .i_flag   (r_d_flag),
    .o_seg_n  (w_glyph)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg_n <= SEG_BLANK;
      r_an_n  <= 4'hF;
    end else begin
      r_seg_n <= w_glyph;
      r_an_n  <= r_phase ? ~(4'b0001 << r_idx) : 4'hF;
    end
  end

  assign seg_n    = r_seg_n;
  assign an_n     = r_an_n;
  assign dp_n     = 1'b1;
  assign disp_vld = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_alu_result_display                                                      |
// | Self-checking bench: frame-level reference model plus glyph table.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_result_display;

  localparam int SD    = 4;
  localparam int BT    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upd = 1'b0;
  logic [1:0] op = 2'd0;
  logic [3:0] result = 4'd0;
  logic       flag = 1'b0;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;
  logic       disp_vld;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_display #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk      (clk),
    .rst      (rst),
    .upd      (upd),
    .op       (op),
    .result   (result),
    .flag     (flag),
    .seg_n    (seg_n),
    .an_n     (an_n),
    .dp_n     (dp_n),
    .disp_vld (disp_vld)
  );

  // Active-high segment art per character, inverted for the common-anode display.
  function automatic logic [6:0] seg_of(input byte ch);
    logic [6:0] hi;
    case (ch)
      "0": hi = 7'h3F;  "1": hi = 7'h06;  "2": hi = 7'h5B;  "3": hi = 7'h4F;
      "4": hi = 7'h66;  "5": hi = 7'h6D;  "6": hi = 7'h7D;  "7": hi = 7'h07;
      "8": hi = 7'h7F;  "9": hi = 7'h6F;  "A": hi = 7'h77;  "S": hi = 7'h6D;
      "P": hi = 7'h73;  "d": hi = 7'h5E;  "C": hi = 7'h39;  "b": hi = 7'h7C;
      "o": hi = 7'h5C;  "E": hi = 7'h79;  default: hi = 7'h00;
    endcase
    return ~hi;
  endfunction

  function automatic byte char_of(input int d, input logic [1:0] o, input logic [3:0] r, input logic f);
    string s3, s2;
    s3 = "ASPd";
    s2 = "CboE";
    case (d)
      3:       return s3[o];
      2:       return f ? s2[o] : 8'd32;
      1:       return (r >= 10) ? 8'd49 : 8'd32;
      default: return byte'(48 + (int'(r) % 10));
    endcase
  endfunction

  // Reference model: edge count k since reset release drives scan position and blink phase.
  int         k = 0;
  int         kerr = 0;
  int         m_idx;
  logic       m_on, m_err_before;
  logic       m_pend = 1'b0, m_vld = 1'b0;
  logic [1:0] m_pop = 2'd0, m_dop = 2'd0;
  logic [3:0] m_pres = 4'd0, m_dres = 4'd0;
  logic       m_pflag = 1'b0, m_dflag = 1'b0;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_an = 4'hF;
  logic       e_vld = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = 0; kerr = 0;
      m_pend = 0; m_vld = 0;
      m_pop = 0; m_pres = 0; m_pflag = 0;
      m_dop = 0; m_dres = 0; m_dflag = 0;
      e_seg = 7'h7F; e_an = 4'hF; e_vld = 0;
    end else begin
      m_idx = (k / SD) % 4;
      m_on  = 1'b1;
      if (m_dop == 2'd3 && m_dflag) m_on = (((k / SD - kerr / SD) / BT) % 2) == 0;
      e_an  = m_on ? ~(4'b0001 << m_idx) : 4'hF;
      e_seg = seg_of(char_of(m_idx, m_dop, m_dres, m_dflag));
      k++;
      if ((k % FRAME) == 0 && (m_pend || upd)) begin
        m_err_before = (m_dop == 2'd3) && m_dflag;
        if (upd) begin
          m_dop = op; m_dres = result; m_dflag = flag;
        end else begin
          m_dop = m_pop; m_dres = m_pres; m_dflag = m_pflag;
        end
        m_pend = 0;
        m_vld  = 1;
        if (!m_err_before && m_dop == 2'd3 && m_dflag) kerr = k;
      end else if (upd) begin
        m_pop = op; m_pres = result; m_pflag = flag;
        m_pend = 1;
      end
      e_vld = m_vld;
    end
  end

  task automatic cmp();
    n_vec++;
    if (seg_n !== e_seg || an_n !== e_an || dp_n !== 1'b1 || disp_vld !== e_vld) begin
      n_bad++;
      $display("FAIL scan k=%0d: got seg_n=%h an_n=%h dp_n=%b vld=%b, required seg_n=%h an_n=%h dp_n=1 vld=%b",
               k, seg_n, an_n, dp_n, disp_vld, e_seg, e_an, e_vld);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) cmp();
      upd = 1'b0;
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [3:0] r, input logic f);
    upd = 1'b1; op = o; result = r; flag = f;
  endtask

  task automatic wait_mod(input int m);
    int guard;
    guard = 0;
    while ((k % FRAME) != m && guard < 3 * FRAME) begin
      idle(1);
      guard++;
    end
    if ((k % FRAME) != m) begin
      n_vec++; n_bad++;
      $display("FAIL frame_align: got k mod %0d = %0d, required %0d", FRAME, k % FRAME, m);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] res;
    logic       fl;
    byte        c3, c2, c1, c0;
  } vec_t;

  vec_t tbl[8];
  byte  seen_ch[4];
  bit   seen[4];
  byte  want;
  int   first_d;

  initial begin
    tbl[0] = '{2'd0, 4'd6,  1'b0, "A", " ", " ", "6"};
    tbl[1] = '{2'd0, 4'd12, 1'b1, "A", "C", "1", "2"};
    tbl[2] = '{2'd1, 4'd3,  1'b1, "S", "b", " ", "3"};
    tbl[3] = '{2'd2, 4'd15, 1'b0, "P", " ", "1", "5"};
    tbl[4] = '{2'd2, 4'd9,  1'b1, "P", "o", " ", "9"};
    tbl[5] = '{2'd3, 4'd0,  1'b1, "d", "E", " ", "0"};
    tbl[6] = '{2'd3, 4'd10, 1'b0, "d", " ", "1", "0"};
    tbl[7] = '{2'd1, 4'd0,  1'b0, "S", " ", " ", "0"};

    #1 rst = 1'b0;
    #20;
    @(negedge clk) rst = 1'b1;
    idle(10);

    // Reset mid-scan with a digit lit: outputs must clear without waiting for a clock.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || disp_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got an_n=%h seg_n=%h vld=%b, required an_n=F seg_n=7F vld=0", an_n, seg_n, disp_vld);
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    first_d = -1;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (an_n == 4'hD && first_d < 0) first_d = i;
    end
    n_vec++;
    if (first_d != SD) begin
      n_bad++;
      $display("FAIL first_tick: got digit-1 slot after %0d cycles, required %0d", first_d, SD);
    end

    // Glyph table: one update mid-frame, then read every lit digit over the following frame.
    foreach (tbl[t]) begin
      wait_mod(5);
      drive(tbl[t].op, tbl[t].res, tbl[t].fl);
      idle(1);
      wait_mod(0);
      for (int d = 0; d < 4; d++) seen[d] = 0;
      for (int c = 0; c < FRAME; c++) begin
        idle(1);
        for (int d = 0; d < 4; d++)
          if (an_n == ~(4'b0001 << d)) begin seen[d] = 1; seen_ch[d] = 0; end
        for (int d = 0; d < 4; d++)
          if (an_n == ~(4'b0001 << d)) begin
            want = (d == 3) ? tbl[t].c3 : (d == 2) ? tbl[t].c2 : (d == 1) ? tbl[t].c1 : tbl[t].c0;
            n_vec++;
            if (seg_n !== seg_of(want)) begin
              n_bad++;
              $display("FAIL glyph entry %0d digit %0d: got seg_n=%h, required '%c' (%h)", t, d, seg_n, want, seg_of(want));
            end
          end
      end
      if (!(tbl[t].op == 2'd3 && tbl[t].fl)) begin
        n_vec++;
        if (!(seen[0] && seen[1] && seen[2] && seen[3])) begin
          n_bad++;
          $display("FAIL digits_lit entry %0d: got lit mask %b%b%b%b, required 1111", t, seen[3], seen[2], seen[1], seen[0]);
        end
      end
    end

    // Two updates inside one frame: only the later one may reach the display.
    wait_mod(3);
    drive(2'd2, 4'd9, 1'b1);
    idle(3);
    drive(2'd0, 4'd12, 1'b1);
    idle(2 * FRAME);

    // Pending update, then another exactly on the commit cycle: the latter wins and nothing lingers.
    wait_mod(6);
    drive(2'd2, 4'd7, 1'b0);
    idle(1);
    wait_mod(FRAME - 1);
    drive(2'd1, 4'd11, 1'b1);
    idle(3 * FRAME);

    // Divide-by-zero blinking, then cleared by a normal result.
    wait_mod(2);
    drive(2'd3, 4'd0, 1'b1);
    idle(4 * FRAME);
    drive(2'd1, 4'd3, 1'b1);
    idle(3 * FRAME);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      idle(1);
      if ($urandom_range(7) == 0)
        drive(2'($urandom_range(3)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
